// File: rtl/dualmem_rd_stream.sv
// Read sequencer for the 512 x 64 dual-port buffer: issues port-B burst reads and
// streams the returned words on a valid/ready interface through a 2-entry output FIFO.
module dualmem_rd_stream #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                mem_en_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_last_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  issue_cnt_q;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic              inflight_q;
  logic              done_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              valid_q, valid_d;
  logic              skid_vld_q, skid_vld_d;
  logic              last_q, last_d;
  logic              pop;
  logic              issue;
  logic [1:0]        credit;

  // FIFO = output register (head) plus one skid entry behind it.
  always_comb begin
    pop    = valid_q & m_ready_i;
    credit = {1'b0, valid_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q} - {1'b0, pop};
    issue  = (state_q == RUN) && (issue_cnt_q != '0) && (credit < 2'd2);

    data_d     = data_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop) begin
      if (skid_vld_q) begin
        data_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (inflight_q) begin
      if (!valid_d) begin
        data_d  = mem_rdata_i;
        valid_d = 1'b1;
      end else begin
        skid_d     = mem_rdata_i;
        skid_vld_d = 1'b1;
      end
    end

    out_cnt_d = pop ? out_cnt_q - LEN_W'(1) : out_cnt_q;
    last_d    = valid_d && (out_cnt_d == LEN_W'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      skid_q      <= '0;
      valid_q     <= 1'b0;
      skid_vld_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      data_q     <= data_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      last_q     <= last_d;
      out_cnt_q  <= out_cnt_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr_q      <= base_i;
              issue_cnt_q <= len_i;
              out_cnt_q   <= len_i;
              state_q     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_W'(1);
            issue_cnt_q <= issue_cnt_q - LEN_W'(1);
            if (issue_cnt_q == LEN_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (out_cnt_q == LEN_W'(1))) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inflight_q && valid_q && skid_vld_q && !pop));

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign mem_en_o   = issue;
  assign mem_we_o   = '0;
  assign mem_addr_o = addr_q;
  assign m_data_o   = data_q;
  assign m_valid_o  = valid_q;
  assign m_last_o   = last_q;

endmodule

// File: tb/tb_dualmem_rd_stream.sv
// Bench for dualmem_rd_stream: port-B memory model, stream monitor, and bursts checked
// against expected words mem[(base+i) mod 512] and the start-relative cycle timing.
module tb_dualmem_rd_stream;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 10;
  localparam int DEPTH  = 512;

  logic                clk_i     = 1'b0;
  logic                rst_ni    = 1'b1;
  logic                start_i   = 1'b0;
  logic [ADDR_W-1:0]   base_i    = '0;
  logic [LEN_W-1:0]    len_i     = '0;
  logic                m_ready_i = 1'b1;
  logic                busy_o, done_o, mem_en_o, m_valid_o, m_last_o;
  logic [DATA_W/8-1:0] mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   m_data_o;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic [DATA_W-1:0]   mem [DEPTH];

  dualmem_rd_stream #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata), .m_data_o(m_data_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_en_o) mem_rdata <= mem[mem_addr_o];
  end

  int total = 0, passed = 0, failed = 0;
  int issued = 0, accepted = 0, done_cnt = 0, done_cyc = 0, stall_viol = 0, credit_viol = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;
  logic [DATA_W-1:0] got_data[$];
  logic              got_last[$];
  int                got_cyc[$];
  logic [ADDR_W-1:0] got_addr[$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      issued     = accepted;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid_o || m_data_o !== prev_data || m_last_o !== prev_last))
        stall_viol++;
      if (mem_en_o) begin
        issued++;
        got_addr.push_back(mem_addr_o);
      end
      if (m_valid_o && m_ready_i) begin
        accepted++;
        got_data.push_back(m_data_o);
        got_last.push_back(m_last_o);
        got_cyc.push_back(cyc);
      end
      if (issued > accepted + 2) credit_viol++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_busy"},   64'(busy_o),     64'(0));
    check({phase, "_done"},   64'(done_o),     64'(0));
    check({phase, "_mem_en"}, 64'(mem_en_o),   64'(0));
    check({phase, "_mem_we"}, 64'(mem_we_o),   64'(0));
    check({phase, "_addr"},   64'(mem_addr_o), 64'(0));
    check({phase, "_valid"},  64'(m_valid_o),  64'(0));
    check({phase, "_last"},   64'(m_last_o),   64'(0));
    check({phase, "_data"},   m_data_o,        64'(0));
  endtask

  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 4 == 0) || (n % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  int start_cyc, beat0, addr0, done0, sv0, cv0;

  task automatic snapshot();
    beat0 = got_data.size();
    addr0 = got_addr.size();
    done0 = done_cnt;
    sv0   = stall_viol;
    cv0   = credit_viol;
  endtask

  task automatic run_burst(input int base, input int len, input int mode, input int restart_at);
    int n, tail;
    snapshot();
    @(posedge clk_i); #1;
    start_cyc = cyc;
    start_i   = 1'b1;
    base_i    = ADDR_W'(base);
    len_i     = LEN_W'(len);
    m_ready_i = ready_for(mode, 0);
    n = 0;
    tail = 0;
    while (n < 6 * len + 40 && tail < 4) begin
      @(posedge clk_i); #1;
      n++;
      if (done_cnt != done0) tail++;
      start_i = (n == restart_at);
      if (start_i) begin
        base_i = ADDR_W'(base + 7);
        len_i  = LEN_W'(3);
      end
      m_ready_i = ready_for(mode, n);
      if (n == 1) check("busy_cycle1", 64'(busy_o), 64'(len != 0));
    end
    m_ready_i = 1'b1;
  endtask

  task automatic verify(input int base, input int len, input bit timed);
    int nb, na;
    nb = got_data.size() - beat0;
    na = got_addr.size() - addr0;
    check("beat_count",  64'(nb), 64'(len));
    check("issue_count", 64'(na), 64'(len));
    check("done_count",  64'(done_cnt - done0), 64'(1));
    check("stall_hold",  64'(stall_viol - sv0), 64'(0));
    check("read_ahead",  64'(credit_viol - cv0), 64'(0));
    check("idle_after",  64'(busy_o), 64'(0));
    for (int i = 0; i < len; i++) begin
      if (i < na) check("addr", 64'(got_addr[addr0 + i]), 64'((base + i) % DEPTH));
      if (i < nb) begin
        check("data", got_data[beat0 + i], mem[ADDR_W'((base + i) % DEPTH)]);
        check("last", 64'(got_last[beat0 + i]), 64'(i == len - 1));
      end
    end
    if (timed) begin
      if (len == 0) begin
        check("done_cycle", 64'(done_cyc - start_cyc), 64'(1));
      end else begin
        if (nb > 0) check("first_beat_cycle", 64'(got_cyc[beat0] - start_cyc), 64'(3));
        if (nb >= len) check("last_beat_cycle", 64'(got_cyc[beat0 + len - 1] - start_cyc), 64'(len + 2));
        check("done_cycle", 64'(done_cyc - start_cyc), 64'(len + 3));
      end
    end
  endtask

  initial begin
    int n, b, l;
    for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) mem[ADDR_W'(i)] = 64'(32'h1000 + i);

    #1 rst_ni = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    run_burst(0, 8, 0, 0);     verify(0, 8, 1);
    run_burst(510, 4, 0, 0);   verify(510, 4, 1);
    run_burst(40, 16, 1, 0);   verify(40, 16, 0);
    run_burst(200, 0, 0, 0);   verify(200, 0, 1);
    run_burst(100, 512, 0, 0); verify(100, 512, 1);
    run_burst(60, 12, 0, 5);   verify(60, 12, 1);

    // Abort a 20-beat burst after 5 beats, then check a fresh burst.
    snapshot();
    @(posedge clk_i); #1;
    start_i = 1'b1; base_i = ADDR_W'(250); len_i = LEN_W'(20); m_ready_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      n++;
    end while (got_data.size() - beat0 < 5 && n < 40);
    check("beats_before_reset", 64'(got_data.size() - beat0), 64'(5));
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("abort");
    done0 = done_cnt;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("no_done_after_abort", 64'(done_cnt - done0), 64'(0));
    check("idle_after_abort", 64'(busy_o), 64'(0));
    run_burst(300, 6, 0, 0); verify(300, 6, 1);

    repeat (3) begin
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 40);
      run_burst(b, l, 2, 0);
      verify(b, l, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
